// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: access sizes,
// FSM states and the natural-alignment rule.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      MT_BYTE  = 2'b00,
      MT_HALF  = 2'b01,
      MT_WORD  = 2'b10,
      MT_DWORD = 2'b11
   } mem_type_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01,
      S_RESP   = 2'b10
   } arb_state_e;

   // An access is aligned when the low address bits below its size are zero.
   function automatic logic is_aligned(input mem_type_e t, input logic [2:0] a);
      logic ok;
      case (t)
         MT_BYTE: ok = 1'b1;
         MT_HALF: ok = (a[0] == 1'b0);
         MT_WORD: ok = (a[1:0] == 2'b00);
         default: ok = (a == 3'b000);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request ports sharing
// one response channel.
interface data_mem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic [1:0]             req_valid;
   logic [1:0]             req_ready;
   logic [1:0]             req_write;
   logic [1:0][1:0]        req_type;
   logic [1:0][ADDR_W-1:0] req_addr;
   logic [1:0][DATA_W-1:0] req_wdata;
   logic [1:0]             resp_valid;
   logic [DATA_W-1:0]      resp_rdata;
   logic                   resp_err;

   modport master (
      output req_valid, req_write, req_type, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_type, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. On a tie the port that was not granted last wins;
// the history bit resets to 1 so port 0 wins the first tie.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);
   logic last_q, last_d;

   always_comb begin
      // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
      gnt_o  = 2'b00;
      last_d = last_q;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
      if (en_i && (|req_i)) last_d = gnt_o[1];
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) last_q <= 1'b1;
      else       last_q <= last_d;
   end
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one combinational-read DataMemory between the core LSU (port 0) and a
// debug/DMA port (port 1): grant, one memory cycle, one response cycle.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   data_mem_arbiter_if.slave req_if,
   output logic              mem_read,
   output logic              mem_write,
   output logic [1:0]        MemType,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
);
   arb_state_e        state_q, state_d;
   logic              port_q, port_d;
   logic              write_q, write_d;
   mem_type_e         type_q, type_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [1:0] gnt;
   logic       gnt_idx;
   logic       grant_en;
   logic [1:0] ready_c;
   logic [1:0] resp_valid_c;
   logic       mem_read_c, mem_write_c;

   assign gnt_idx = gnt[1];

   rr_arbiter2 u_rr (
      .clk   (clk),
      .reset (reset),
      .req_i (req_if.req_valid),
      .en_i  (grant_en),
      .gnt_o (gnt)
   );

   always_comb begin
      state_d      = state_q;
      port_d       = port_q;
      write_d      = write_q;
      type_d       = type_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      grant_en     = 1'b0;
      ready_c      = 2'b00;
      resp_valid_c = 2'b00;
      mem_read_c   = 1'b0;
      mem_write_c  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // No grant while reset is held, so nothing is accepted and then abandoned.
            grant_en = (|req_if.req_valid) && !reset;
            if (grant_en) begin
               ready_c = gnt;
               port_d  = gnt_idx;
               write_d = req_if.req_write[gnt_idx];
               type_d  = mem_type_e'(req_if.req_type[gnt_idx]);
               addr_d  = req_if.req_addr[gnt_idx];
               wdata_d = req_if.req_wdata[gnt_idx];
               rdata_d = '0;
               err_d   = !is_aligned(mem_type_e'(req_if.req_type[gnt_idx]),
                                     req_if.req_addr[gnt_idx][2:0]);
               state_d = err_d ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: begin
            // Strobes stay ungated by reset: a write on the reset edge still commits.
            mem_write_c = write_q;
            mem_read_c  = !write_q;
            rdata_d     = write_q ? '0 : read_data;
            state_d     = S_RESP;
         end
         S_RESP: begin
            resp_valid_c[port_q] = !reset;
            state_d              = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         port_q  <= 1'b0;
         write_q <= 1'b0;
         type_q  <= MT_BYTE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         write_q <= write_d;
         type_q  <= type_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_if.req_ready  = ready_c;
   assign req_if.resp_valid = resp_valid_c;
   assign req_if.resp_rdata = rdata_q;
   assign req_if.resp_err   = err_q;
   assign mem_read          = mem_read_c;
   assign mem_write         = mem_write_c;
   assign MemType           = type_q;
   assign address           = addr_q;
   assign write_data        = wdata_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a little-endian byte-array DataMemory
// model and hand-computed expectations.
module tb_data_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 64;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          mem_read, mem_write;
   logic [1:0]    mem_type;
   logic [AW-1:0] address;
   logic [DW-1:0] write_data;
   logic [DW-1:0] read_data;
   logic [7:0]    mem [256];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic          mon_en = 1'b0;

   always #5 clk = ~clk;

   data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_if     (bus),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .MemType    (mem_type),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data)
   );

   always @(posedge clk)
      if (mem_write)
         for (int i = 0; i < (1 << mem_type); i++)
            mem[address[7:0] + 8'(i)] <= write_data[8*i +: 8];

   always_comb begin
      read_data = '0;
      for (int i = 0; i < 8; i++)
         if (i < (1 << mem_type)) read_data[8*i +: 8] = mem[address[7:0] + 8'(i)];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk)
      if (mon_en) begin
         check("mon_ready_onehot", 64'($onehot0(bus.req_ready)), 64'd1);
         check("mon_mem_excl", 64'(mem_read & mem_write), 64'd0);
         check("mon_resp_onehot", 64'($onehot0(bus.resp_valid)), 64'd1);
      end

   task automatic clear_reqs();
      bus.req_valid = 2'b00;
      bus.req_write = 2'b00;
      bus.req_type  = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   task automatic set_req(input int p, input logic w, input mem_type_e t,
                          input logic [63:0] a, input logic [63:0] d);
      bus.req_valid[p] = 1'b1;
      bus.req_write[p] = w;
      bus.req_type[p]  = t;
      bus.req_addr[p]  = a;
      bus.req_wdata[p] = d;
   endtask

   task automatic wait_ready(output logic [1:0] r);
      int n = 0;
      @(negedge clk);
      while (bus.req_ready == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      r = bus.req_ready;
   endtask

   // Starts in the cycle after accept; counts cycles up to and including the response.
   task automatic wait_resp(output int lat, output int wr, output int rd);
      lat = 0; wr = 0; rd = 0;
      do begin
         @(negedge clk);
         lat++;
         wr += int'(mem_write);
         rd += int'(mem_read);
      end while (bus.resp_valid == 2'b00 && lat < 10);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      clear_reqs();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic txn(input string tag, input int p, input logic w, input mem_type_e t,
                      input logic [63:0] a, input logic [63:0] d, input int exp_lat,
                      input logic [63:0] exp_rdata, input logic exp_err,
                      input int exp_wr, input int exp_rd);
      logic [1:0] r;
      int lat, wr, rd;
      @(posedge clk); #1;
      set_req(p, w, t, a, d);
      wait_ready(r);
      check({tag, "_ready"}, 64'(r), 64'd1 << p);
      @(posedge clk); #1;
      bus.req_valid[p] = 1'b0;
      wait_resp(lat, wr, rd);
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd1 << p);
      check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
      check({tag, "_err"}, 64'(bus.resp_err), 64'(exp_err));
      check({tag, "_wr_cycles"}, 64'(wr), 64'(exp_wr));
      check({tag, "_rd_cycles"}, 64'(rd), 64'(exp_rd));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
      check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
      check({tag, "_rdata"}, bus.resp_rdata, 64'd0);
      check({tag, "_err"}, 64'(bus.resp_err), 64'd0);
      check({tag, "_mem_read"}, 64'(mem_read), 64'd0);
      check({tag, "_mem_write"}, 64'(mem_write), 64'd0);
      check({tag, "_memtype"}, 64'(mem_type), 64'd0);
      check({tag, "_address"}, address, 64'd0);
      check({tag, "_wdata"}, write_data, 64'd0);
   endtask

   initial begin
      logic [1:0] r;
      int lat, wr, rd;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      clear_reqs();

      // A request held during reset must not be granted.
      set_req(0, 1'b0, MT_BYTE, 64'h0, 64'h0);
      repeat (2) begin
         @(negedge clk);
         check("rst_hold_ready", 64'(bus.req_ready), 64'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      clear_reqs();
      mon_en = 1'b1;
      @(negedge clk);
      check_reset_outputs("post_reset");

      // Dword write then read back on port 0.
      txn("dw_write", 0, 1'b1, MT_DWORD, 64'h10, 64'hDEADBEEFCAFEBABE, 2, 64'h0, 1'b0, 1, 0);
      txn("dw_read", 0, 1'b0, MT_DWORD, 64'h10, 64'h0, 2, 64'hDEADBEEFCAFEBABE, 1'b0, 0, 1);

      // Simultaneous requests after reset: port 0 first, then port 1 reads its data.
      pulse_reset();
      set_req(0, 1'b1, MT_WORD, 64'h20, 64'h12345678);
      set_req(1, 1'b0, MT_WORD, 64'h20, 64'h0);
      wait_ready(r);
      check("tie_first_grant", 64'(r), 64'b01);
      @(posedge clk); #1;
      bus.req_valid[0] = 1'b0;
      wait_resp(lat, wr, rd);
      check("tie_p0_resp", 64'(bus.resp_valid), 64'b01);
      check("tie_p0_wr_cycles", 64'(wr), 64'd1);
      wait_ready(r);
      check("tie_second_grant", 64'(r), 64'b10);
      @(posedge clk); #1;
      bus.req_valid[1] = 1'b0;
      wait_resp(lat, wr, rd);
      check("tie_p1_resp", 64'(bus.resp_valid), 64'b10);
      check("tie_p1_rdata", bus.resp_rdata, 64'h12345678);
      check("tie_p1_latency", 64'(lat), 64'd2);

      // Both ports held valid: grants alternate starting with port 0.
      @(posedge clk); #1;
      set_req(0, 1'b0, MT_BYTE, 64'h20, 64'h0);
      set_req(1, 1'b0, MT_BYTE, 64'h21, 64'h0);
      for (int k = 0; k < 6; k++) begin
         wait_ready(r);
         check($sformatf("rr_grant%0d", k), 64'(r), (k % 2 == 0) ? 64'b01 : 64'b10);
      end
      @(posedge clk); #1;
      clear_reqs();
      repeat (4) @(negedge clk);

      // Alignment boundaries.
      txn("mis_half", 1, 1'b0, MT_HALF, 64'h31, 64'h0, 1, 64'h0, 1'b1, 0, 0);
      txn("mis_word_wr", 0, 1'b1, MT_WORD, 64'h22, 64'hFFFFFFFF, 1, 64'h0, 1'b1, 0, 0);
      txn("ali_half", 1, 1'b0, MT_HALF, 64'h22, 64'h0, 2, 64'h1234, 1'b0, 0, 1);
      txn("mis_dword", 0, 1'b0, MT_DWORD, 64'h14, 64'h0, 1, 64'h0, 1'b1, 0, 0);
      txn("byte_odd", 0, 1'b0, MT_BYTE, 64'h13, 64'h0, 2, 64'hCA, 1'b0, 0, 1);

      // Reset during RESP of a byte read: response suppressed, outputs cleared.
      @(posedge clk); #1;
      set_req(0, 1'b0, MT_BYTE, 64'h30, 64'h0);
      wait_ready(r);
      check("rst_resp_ready", 64'(r), 64'b01);
      @(posedge clk); #1;
      bus.req_valid[0] = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_resp_suppressed", 64'(bus.resp_valid), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_in_resp");
      txn("after_rst", 0, 1'b0, MT_DWORD, 64'h10, 64'h0, 2, 64'hDEADBEEFCAFEBABE, 1'b0, 0, 1);

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
